// File: rtl/pipeline_stall_controller_if.sv
// Interface: pipeline_stall_controller_if
// Groups the hazard inputs and the pipeline-register controls of the stall
// sequencer so that the pipeline and the controller share one bundle.
//   master : pipeline side (drives hazard/memory status, receives controls)
//   slave  : stall controller (receives hazard/memory status, drives controls)
// Signals:
//   IFID_op1/IFID_op2  source specifiers of the instruction in ID
//   IDEX_op1           destination specifier of the instruction in EX
//   IDEX_MemRead       instruction in EX is a load
//   Branch_Taken       branch in EX resolved taken
//   Mem_Req/Mem_Ready  MEM-stage access request / completion
//   PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble, EXMEM_Hold, STALL
//                      pipeline-register controls
//   Stall_Count        saturating count of cycles with PCWrite==0
//   Timeout_Err        sticky memory-timeout flag
interface pipeline_stall_controller_if #(
    parameter int REG_W = 4,
    parameter int CNT_W = 16
);
    logic [REG_W-1:0] IFID_op1;
    logic [REG_W-1:0] IFID_op2;
    logic [REG_W-1:0] IDEX_op1;
    logic             IDEX_MemRead;
    logic             Branch_Taken;
    logic             Mem_Req;
    logic             Mem_Ready;

    logic             PCWrite;
    logic             IFID_Write;
    logic             IFID_Flush;
    logic             IDEX_Bubble;
    logic             EXMEM_Hold;
    logic             STALL;
    logic [CNT_W-1:0] Stall_Count;
    logic             Timeout_Err;

    modport master (
        output IFID_op1, IFID_op2, IDEX_op1, IDEX_MemRead,
               Branch_Taken, Mem_Req, Mem_Ready,
        input  PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble,
               EXMEM_Hold, STALL, Stall_Count, Timeout_Err
    );

    modport slave (
        input  IFID_op1, IFID_op2, IDEX_op1, IDEX_MemRead,
               Branch_Taken, Mem_Req, Mem_Ready,
        output PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble,
               EXMEM_Hold, STALL, Stall_Count, Timeout_Err
    );
endinterface

// File: rtl/pipeline_stall_controller.sv
// Module: pipeline_stall_controller
// Central stall/flush sequencer for the 5-stage pipeline. Hazard detection
// decides; this block sequences. It merges load-use hazards (ID vs EX),
// taken branches (resolved in EX) and multi-cycle data-memory waits (MEM)
// into PC, IF/ID, ID/EX and EX/MEM register controls, counts stalled cycles
// and flags memory waits that run into the timeout.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous, active-low reset
//   bus  slave view of pipeline_stall_controller_if (hazard inputs in,
//        pipeline-register controls, Stall_Count and Timeout_Err out)
module pipeline_stall_controller #(
    parameter int REG_W       = 4,
    parameter int CNT_W       = 16,
    parameter int BR_PENALTY  = 2,
    parameter int MEM_TIMEOUT = 15,
    parameter int SKIP_R0     = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    pipeline_stall_controller_if.slave   bus
);
    localparam int FLUSH_W = (BR_PENALTY > 1) ? $clog2(BR_PENALTY) : 1;
    localparam int WAIT_W  = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [FLUSH_W-1:0] FLUSH_RELOAD = FLUSH_W'(BR_PENALTY - 1);
    localparam logic [WAIT_W-1:0]  WAIT_LIMIT   = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0]  WAIT_FIRST   = WAIT_W'(1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [FLUSH_W-1:0] flush_cnt, flush_nxt;
    logic [WAIT_W-1:0]  wait_cnt, wait_nxt;
    logic [CNT_W-1:0]   stall_count;
    logic               timeout_err;
    logic               timeout_set;

    logic pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold;
    logic mem_stall, load_use, op1_is_r0;

    assign mem_stall = bus.Mem_Req & ~bus.Mem_Ready;
    assign op1_is_r0 = (SKIP_R0 != 0) && (bus.IDEX_op1 == {REG_W{1'b0}});
    assign load_use  = bus.IDEX_MemRead
                     & ((bus.IFID_op1 == bus.IDEX_op1) | (bus.IFID_op2 == bus.IDEX_op1))
                     & ~op1_is_r0;

    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned; otherwise synthesis would infer latches.
    always_comb begin
        state_nxt   = state;
        flush_nxt   = flush_cnt;
        wait_nxt    = wait_cnt;
        timeout_set = 1'b0;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        exmem_hold  = 1'b0;

        case (state)
            RUN: begin
                if (mem_stall) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    exmem_hold = 1'b1;
                    state_nxt  = MEM_WAIT;
                    wait_nxt   = WAIT_FIRST;
                end else if (bus.Branch_Taken) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    if (BR_PENALTY > 1) begin
                        state_nxt = FLUSH;
                        flush_nxt = FLUSH_RELOAD;
                    end
                end else if (load_use) begin
                    // The bubble clears IDEX_MemRead, so this stall lasts one cycle.
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                end
            end

            FLUSH: begin
                if (mem_stall) begin
                    // Memory freeze wins; the remaining flush cycles are dropped.
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    exmem_hold = 1'b1;
                    state_nxt  = MEM_WAIT;
                    wait_nxt   = WAIT_FIRST;
                    flush_nxt  = '0;
                end else begin
                    // load_use is ignored: the instruction in ID is being squashed.
                    ifid_flush = 1'b1;
                    if (bus.Branch_Taken) begin
                        idex_bubble = 1'b1;
                        flush_nxt   = FLUSH_RELOAD;
                    end else if (flush_cnt <= FLUSH_W'(1)) begin
                        state_nxt = RUN;
                        flush_nxt = '0;
                    end else begin
                        flush_nxt = flush_cnt - 1'b1;
                    end
                end
            end

            MEM_WAIT: begin
                // Full freeze; branch and load-use re-present once EX moves again.
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                exmem_hold = 1'b1;
                if (bus.Mem_Ready) begin
                    state_nxt = RUN;
                    wait_nxt  = '0;
                end else if (wait_cnt == WAIT_LIMIT) begin
                    timeout_set = 1'b1;
                    state_nxt   = RUN;
                    wait_nxt    = '0;
                end else begin
                    wait_nxt = wait_cnt + 1'b1;
                end
            end

            default: begin
                state_nxt = RUN;
                flush_nxt = '0;
                wait_nxt  = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            flush_cnt <= '0;
            wait_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_nxt;
            wait_cnt  <= wait_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_count <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (!pc_write && (stall_count != {CNT_W{1'b1}})) begin
                stall_count <= stall_count + 1'b1;
            end
            if (timeout_set) begin
                timeout_err <= 1'b1;
            end
        end
    end

    // NOTE: controls are gated by rst so the pipeline is held with every
    // register control deasserted for the whole reset, not just after an edge.
    assign bus.PCWrite     = rst & pc_write;
    assign bus.IFID_Write  = rst & ifid_write;
    assign bus.IFID_Flush  = rst & ifid_flush;
    assign bus.IDEX_Bubble = rst & idex_bubble;
    assign bus.EXMEM_Hold  = rst & exmem_hold;
    assign bus.STALL       = rst & ~pc_write;
    assign bus.Stall_Count = stall_count;
    assign bus.Timeout_Err = timeout_err;
endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Testbench: tb_pipeline_stall_controller
// Directed vector table for the documented scenarios, hand-written sequences
// for timeout and reset-during-wait, and randomized stimulus compared against
// a cycle-level behavioural model of the sequencing rules.
module tb_pipeline_stall_controller;
    localparam int REG_W       = 4;
    localparam int CNT_W       = 16;
    localparam int BR_PENALTY  = 2;
    localparam int MEM_TIMEOUT = 15;

    // Control vector order: {PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble, EXMEM_Hold, STALL}
    localparam logic [5:0] C_RST = 6'b000000;
    localparam logic [5:0] C_DEF = 6'b110000;
    localparam logic [5:0] C_LU  = 6'b000101;
    localparam logic [5:0] C_BR  = 6'b111100;
    localparam logic [5:0] C_FL  = 6'b111000;
    localparam logic [5:0] C_MW  = 6'b000011;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pipeline_stall_controller_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

    pipeline_stall_controller #(
        .REG_W(REG_W), .CNT_W(CNT_W), .BR_PENALTY(BR_PENALTY),
        .MEM_TIMEOUT(MEM_TIMEOUT), .SKIP_R0(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [3:0] op1;
        logic [3:0] op2;
        logic [3:0] idex;
        logic       rd;
        logic       br;
        logic       mreq;
        logic       mrdy;
        logic [5:0] exp_ctl;
        int         exp_cnt;
    } vec_t;

    vec_t tbl[$];
    int checks   = 0;
    int failures = 0;

    // Behavioural model: how many more flush cycles are owed, whether the
    // pipeline is frozen on memory and for how many wait cycles so far.
    int m_flush_left;
    bit m_frozen;
    int m_waited;
    int m_stalls;
    bit m_terr;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    function automatic vec_t mk(int op1, int op2, int idex, int rd, int br, int mreq, int mrdy,
                                logic [5:0] ctl, int cnt);
        vec_t v;
        v.op1 = 4'(op1);  v.op2 = 4'(op2);  v.idex = 4'(idex);
        v.rd = rd[0];  v.br = br[0];  v.mreq = mreq[0];  v.mrdy = mrdy[0];
        v.exp_ctl = ctl;  v.exp_cnt = cnt;
        return v;
    endfunction

    function automatic logic [5:0] dut_ctl();
        return {bus.PCWrite, bus.IFID_Write, bus.IFID_Flush, bus.IDEX_Bubble,
                bus.EXMEM_Hold, bus.STALL};
    endfunction

    task automatic drive(input vec_t v);
        bus.IFID_op1     = v.op1;
        bus.IFID_op2     = v.op2;
        bus.IDEX_op1     = v.idex;
        bus.IDEX_MemRead = v.rd;
        bus.Branch_Taken = v.br;
        bus.Mem_Req      = v.mreq;
        bus.Mem_Ready    = v.mrdy;
    endtask

    function automatic bit model_load_use();
        return bus.IDEX_MemRead && (bus.IDEX_op1 != 4'd0) &&
               ((bus.IFID_op1 == bus.IDEX_op1) || (bus.IFID_op2 == bus.IDEX_op1));
    endfunction

    function automatic logic [5:0] model_ctl();
        if (!rst) return C_RST;
        if (m_frozen) return C_MW;
        if (bus.Mem_Req && !bus.Mem_Ready) return C_MW;
        if (bus.Branch_Taken) return C_BR;
        if (m_flush_left > 0) return C_FL;
        if (model_load_use()) return C_LU;
        return C_DEF;
    endfunction

    task automatic model_reset();
        m_flush_left = 0;
        m_frozen     = 0;
        m_waited     = 0;
        m_stalls     = 0;
        m_terr       = 0;
    endtask

    task automatic model_advance(input logic [5:0] ctl);
        if (!ctl[5] && m_stalls < (1 << CNT_W) - 1) m_stalls++;
        if (m_frozen) begin
            if (bus.Mem_Ready) begin
                m_frozen = 0;
            end else if (m_waited == MEM_TIMEOUT) begin
                m_terr   = 1;
                m_frozen = 0;
            end else begin
                m_waited++;
            end
        end else if (bus.Mem_Req && !bus.Mem_Ready) begin
            m_frozen     = 1;
            m_waited     = 1;
            m_flush_left = 0;
        end else if (bus.Branch_Taken) begin
            m_flush_left = BR_PENALTY - 1;
        end else if (m_flush_left > 0) begin
            m_flush_left--;
        end
    endtask

    // One clock cycle: inputs are already driven; sample mid-cycle, then
    // advance the model across the rising edge.
    task automatic step(input string tag, input bit use_tbl, input logic [5:0] t_ctl, input int t_cnt);
        logic [5:0] m_ctl;
        @(negedge clk);
        m_ctl = model_ctl();
        if (use_tbl) begin
            check({tag, " ctl"}, 32'(dut_ctl()), 32'(t_ctl));
            check({tag, " cnt"}, 32'(bus.Stall_Count), 32'(t_cnt));
        end else begin
            check({tag, " ctl"}, 32'(dut_ctl()), 32'(m_ctl));
            check({tag, " cnt"}, 32'(bus.Stall_Count), 32'(m_stalls));
            check({tag, " terr"}, 32'(bus.Timeout_Err), 32'(m_terr));
        end
        @(posedge clk);
        model_advance(m_ctl);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v;
        vec_t idle;
        int base;

        idle = mk(0, 0, 0, 0, 0, 0, 0, C_DEF, 0);
        // Documented scenarios, one entry per cycle after reset release.
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, C_DEF, 0));  // idle
        tbl.push_back(mk(1, 5, 5, 1, 0, 0, 0, C_LU,  0));  // load-use via op2
        tbl.push_back(mk(1, 5, 5, 0, 0, 0, 0, C_DEF, 1));  // bubble dropped MemRead
        tbl.push_back(mk(0, 2, 0, 1, 0, 0, 0, C_DEF, 1));  // r0 never hazards
        tbl.push_back(mk(4, 4, 3, 1, 0, 0, 0, C_DEF, 1));  // specifier mismatch
        tbl.push_back(mk(7, 2, 7, 1, 0, 0, 0, C_LU,  1));  // load-use via op1
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, C_BR,  2));  // branch taken
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, C_FL,  2));  // second flush cycle
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, C_DEF, 2));
        tbl.push_back(mk(1, 5, 5, 1, 1, 0, 0, C_BR,  2));  // branch beats load-use
        tbl.push_back(mk(1, 5, 5, 1, 0, 0, 0, C_FL,  2));  // load-use ignored in flush
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, C_DEF, 2));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, C_MW,  2));  // memory wait starts
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, C_MW,  3));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, C_MW,  4));  // branch during wait ignored
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, C_MW,  5));  // ready: still frozen
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, C_DEF, 6));  // four frozen cycles
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, C_DEF, 6));  // req+ready same cycle
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, C_BR,  6));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, C_MW,  6));  // mem stall inside flush
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, C_MW,  7));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, C_DEF, 8));  // leftover flush dropped
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, C_BR,  8));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, C_BR,  8));  // branch reloads flush
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, C_FL,  8));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, C_DEF, 8));

        // Reset state
        drive(idle);
        model_reset();
        #2;
        check("reset ctl", 32'(dut_ctl()), 32'(C_RST));
        check("reset cnt", 32'(bus.Stall_Count), 32'd0);
        check("reset terr", 32'(bus.Timeout_Err), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i]);
            step($sformatf("tbl%0d", i), 1'b1, tbl[i].exp_ctl, tbl[i].exp_cnt);
        end
        check("tbl terr", 32'(bus.Timeout_Err), 32'd0);

        // Randomized traffic against the model; long waits are ended early so
        // the timeout is exercised only by its own sequence below.
        for (int n = 0; n < 400; n++) begin
            v = idle;
            v.op1  = 4'($urandom_range(0, 3));
            v.op2  = 4'($urandom_range(0, 3));
            v.idex = 4'($urandom_range(0, 3));
            v.rd   = ($urandom_range(0, 2) == 0);
            v.br   = ($urandom_range(0, 5) == 0);
            v.mreq = ($urandom_range(0, 3) == 0);
            v.mrdy = ($urandom_range(0, 1) == 0) || (m_waited >= 8);
            drive(v);
            step($sformatf("rnd%0d", n), 1'b0, C_DEF, 0);
        end

        // Drain to a quiet RUN state.
        v = idle;
        v.mrdy = 1'b1;
        drive(v);
        repeat (3) step("drain", 1'b0, C_DEF, 0);

        // Timeout: ready never arrives; one RUN freeze plus MEM_TIMEOUT wait cycles.
        base = m_stalls;
        v = idle;
        v.mreq = 1'b1;
        drive(v);
        for (int k = 0; k <= MEM_TIMEOUT; k++) begin
            step($sformatf("tmo%0d", k), 1'b0, C_DEF, 0);
            if (k == MEM_TIMEOUT - 1) check("tmo not yet", 32'(bus.Timeout_Err), 32'd0);
        end
        drive(idle);
        step("tmo exit", 1'b1, C_DEF, base + MEM_TIMEOUT + 1);
        check("tmo sticky", 32'(bus.Timeout_Err), 32'd1);
        repeat (3) step("tmo hold", 1'b0, C_DEF, 0);
        check("tmo still set", 32'(bus.Timeout_Err), 32'd1);

        // Reset while frozen on memory.
        v = idle;
        v.mreq = 1'b1;
        drive(v);
        repeat (2) step("pre rst", 1'b0, C_DEF, 0);
        rst = 1'b0;
        #1;
        model_reset();
        check("rst PCWrite", 32'(bus.PCWrite), 32'd0);
        check("rst EXMEM_Hold", 32'(bus.EXMEM_Hold), 32'd0);
        check("rst cnt", 32'(bus.Stall_Count), 32'd0);
        check("rst terr", 32'(bus.Timeout_Err), 32'd0);
        @(posedge clk);
        #1;
        drive(idle);
        rst = 1'b1;
        step("post rst", 1'b1, C_DEF, 0);
        check("post rst terr", 32'(bus.Timeout_Err), 32'd0);
        repeat (2) step("post rst run", 1'b0, C_DEF, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
